// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared state encoding and width limits for the I2S receiver.
// Revision : 1.0
// ============================================================================
package i2s_pkg;

    localparam int MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } i2s_state_t;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2s_edge_sync
// Brief    : Two-flop synchronisers for sck/ws/sd plus sck rising-edge pulse.
// Revision : 1.0
// ============================================================================
module i2s_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sck,
    input  logic ws,
    input  logic sd,
    output logic sck_rise,
    output logic ws_s,
    output logic sd_s
);

    logic [1:0] r_sck_sync;
    logic [1:0] r_ws_sync;
    logic [1:0] r_sd_sync;
    logic       r_sck_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck_sync <= 2'b00;
            r_ws_sync  <= 2'b00;
            r_sd_sync  <= 2'b00;
            r_sck_d    <= 1'b0;
        end else begin
            r_sck_sync <= {r_sck_sync[0], sck};
            r_ws_sync  <= {r_ws_sync[0], ws};
            r_sd_sync  <= {r_sd_sync[0], sd};
            r_sck_d    <= r_sck_sync[1];
        end
    end

    // ws/sd share the sck synchroniser depth, so they are aligned at the pulse
    assign sck_rise = r_sck_sync[1] & ~r_sck_d;
    assign ws_s     = r_ws_sync[1];
    assign sd_s     = r_sd_sync[1];

endmodule : i2s_edge_sync
`default_nettype wire

// File: rtl/i2s_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_ctrl
// Brief    : I2S receiver delivering MSB-aligned stereo pairs over valid/ready.
// Revision : 1.0
// ============================================================================
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    input  logic              enable,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun
);

    localparam int CNT_W = $clog2(MAX_DATA_W + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DATA_W);

    logic              w_sck_rise;
    logic              w_ws_s;
    logic              w_sd_s;
    logic              r_ws_d;
    i2s_state_t        r_state;
    i2s_state_t        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_word_l;
    logic [DATA_W-1:0] w_word_wr;
    logic              w_in_word;
    logic              w_boundary;
    logic              w_pair_done;

    i2s_edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (i2s_sck),
        .ws       (i2s_ws),
        .sd       (i2s_sd),
        .sck_rise (w_sck_rise),
        .ws_s     (w_ws_s),
        .sd_s     (w_sd_s)
    );

    assign w_in_word   = enable && (r_state == ST_LEFT || r_state == ST_RIGHT);
    assign w_boundary  = (w_ws_s != r_ws_d);
    assign w_pair_done = enable && (r_state == ST_RIGHT) && w_sck_rise && w_boundary;

    // Current word with the incoming bit placed; bits past DATA_W fall off
    always_comb begin
        w_word_wr = r_shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(r_cnt) == DATA_W - 1 - i) begin
                w_word_wr[i] = w_sd_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_SYNC;
                ST_SYNC:  if (w_sck_rise && r_ws_d && !w_ws_s) w_next_state = ST_LEFT;
                ST_LEFT:  if (w_sck_rise && w_boundary) w_next_state = ST_RIGHT;
                ST_RIGHT: if (w_sck_rise && w_boundary) w_next_state = ST_LEFT;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ws_d   <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_word_l <= '0;
        end else begin
            if (w_sck_rise) begin
                r_ws_d <= w_ws_s;
            end
            if (!w_in_word) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (w_sck_rise) begin
                if (w_boundary) begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    if (r_state == ST_LEFT) begin
                        r_word_l <= w_word_wr;
                    end
                end else begin
                    r_shift <= w_word_wr;
                    if (r_cnt != C_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // A new pair only displaces the held one if the consumer takes it this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (w_pair_done && (!sample_valid || sample_ready)) begin
                sample_l     <= r_word_l;
                sample_r     <= w_word_wr;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (w_pair_done && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule : i2s_rx_ctrl
`default_nettype wire

// File: tb/tb_i2s_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_rx_ctrl
// Brief    : Directed self-checking bench for i2s_rx_ctrl (DATA_W=16).
// Revision : 1.0
// ============================================================================
module tb_i2s_rx_ctrl;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i2s_sck = 1'b0;
    logic              i2s_ws = 1'b0;
    logic              i2s_sd = 1'b0;
    logic              enable = 1'b0;
    logic              ovr_clr = 1'b0;
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready = 1'b1;
    logic              overrun;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [31:0]       pair_q[$];

    i2s_rx_ctrl #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .enable       (enable),
        .ovr_clr      (ovr_clr),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Each negedge with valid&ready precedes exactly one transfer edge
    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            pair_q.push_back({sample_l, sample_r});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic ws, input logic sd);
        i2s_ws = ws;
        i2s_sd = sd;
        #40 i2s_sck = 1'b1;
        #40 i2s_sck = 1'b0;
    endtask

    // Standard I2S: each word's LSB rides on the first bit of the opposite ws
    task automatic send_frame(input logic [31:0] l, input int lb, input logic [31:0] r, input int rb);
        for (int i = lb - 1; i >= 1; i--) bit_out(1'b0, l[i]);
        bit_out(1'b1, l[0]);
        for (int i = rb - 1; i >= 1; i--) bit_out(1'b1, r[i]);
        bit_out(1'b0, r[0]);
        #100;
    endtask

    task automatic drive_sync();
        @(posedge clk);
        #2;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] word_l;
        logic [31:0] word_r;

        // Reset state
        #23;
        sample_point();
        check("rst_l", 64'(sample_l), 64'h0);
        check("rst_r", 64'(sample_r), 64'h0);
        check("rst_valid", 64'(sample_valid), 64'h0);
        check("rst_ovr", 64'(overrun), 64'h0);
        drive_sync();
        rst = 1'b0;
        enable = 1'b1;
        #50;

        // 16-bit frames, first frame only synchronises
        pair_q.delete();
        repeat (3) send_frame(32'hA5C3, 16, 32'h1234, 16);
        check("a_count", 64'(pair_q.size()), 64'd2);
        if (pair_q.size() == 2) begin
            check("a_pair0", 64'(pair_q[0]), 64'hA5C3_1234);
            check("a_pair1", 64'(pair_q[1]), 64'hA5C3_1234);
        end
        check("a_valid_low", 64'(sample_valid), 64'h0);

        // 24-bit words truncated to first 16 bits
        pair_q.delete();
        send_frame(32'hABCDEF, 24, 32'h123456, 24);
        check("b_count", 64'(pair_q.size()), 64'd1);
        if (pair_q.size() == 1) check("b_pair", 64'(pair_q[0]), 64'hABCD_1234);

        // 8-bit words zero-padded
        pair_q.delete();
        send_frame(32'h81, 8, 32'h7F, 8);
        check("c_count", 64'(pair_q.size()), 64'd1);
        if (pair_q.size() == 1) check("c_pair", 64'(pair_q[0]), 64'h8100_7F00);

        // Backpressure and overrun
        pair_q.delete();
        drive_sync();
        sample_ready = 1'b0;
        send_frame(32'h1111, 16, 32'h2222, 16);
        check("d_valid", 64'(sample_valid), 64'h1);
        check("d_ovr0", 64'(overrun), 64'h0);
        send_frame(32'h3333, 16, 32'h4444, 16);
        check("d_ovr1", 64'(overrun), 64'h1);
        check("d_hold_l", 64'(sample_l), 64'h1111);
        check("d_hold_r", 64'(sample_r), 64'h2222);
        send_frame(32'h5555, 16, 32'h6666, 16);
        check("d_hold2_l", 64'(sample_l), 64'h1111);
        drive_sync();
        ovr_clr = 1'b1;
        drive_sync();
        ovr_clr = 1'b0;
        sample_point();
        check("d_ovr_clr", 64'(overrun), 64'h0);
        check("d_valid_kept", 64'(sample_valid), 64'h1);
        drive_sync();
        sample_ready = 1'b1;
        sample_point();
        sample_point();
        check("d_valid_drop", 64'(sample_valid), 64'h0);
        check("d_count", 64'(pair_q.size()), 64'd1);
        if (pair_q.size() == 1) check("d_pair", 64'(pair_q[0]), 64'h1111_2222);

        // Enable dropped mid-left: aborted frame yields nothing
        pair_q.delete();
        word_l = 32'hDEAD;
        word_r = 32'hBEEF;
        for (int i = 15; i >= 8; i--) bit_out(1'b0, word_l[i]);
        drive_sync();
        enable = 1'b0;
        #50;
        drive_sync();
        enable = 1'b1;
        for (int i = 7; i >= 1; i--) bit_out(1'b0, word_l[i]);
        bit_out(1'b1, word_l[0]);
        for (int i = 15; i >= 1; i--) bit_out(1'b1, word_r[i]);
        bit_out(1'b0, word_r[0]);
        #100;
        check("e_no_pair", 64'(pair_q.size()), 64'd0);
        send_frame(32'h0F0F, 16, 32'hF0F0, 16);
        check("e_count", 64'(pair_q.size()), 64'd1);
        if (pair_q.size() == 1) check("e_pair", 64'(pair_q[0]), 64'h0F0F_F0F0);

        // Reset mid-right while a pair is held
        drive_sync();
        sample_ready = 1'b0;
        send_frame(32'hAAAA, 16, 32'h5555, 16);
        check("f_valid_pre", 64'(sample_valid), 64'h1);
        word_l = 32'h3C3C;
        word_r = 32'hC3C3;
        for (int i = 15; i >= 1; i--) bit_out(1'b0, word_l[i]);
        bit_out(1'b1, word_l[0]);
        for (int i = 15; i >= 12; i--) bit_out(1'b1, word_r[i]);
        drive_sync();
        rst = 1'b1;
        sample_point();
        check("f_rst_l", 64'(sample_l), 64'h0);
        check("f_rst_r", 64'(sample_r), 64'h0);
        check("f_rst_valid", 64'(sample_valid), 64'h0);
        check("f_rst_ovr", 64'(overrun), 64'h0);
        drive_sync();
        rst = 1'b0;
        sample_ready = 1'b1;
        pair_q.delete();
        for (int i = 11; i >= 1; i--) bit_out(1'b1, word_r[i]);
        bit_out(1'b0, word_r[0]);
        #100;
        check("f_no_pair", 64'(pair_q.size()), 64'd0);
        send_frame(32'h6789, 16, 32'h9876, 16);
        check("f_count", 64'(pair_q.size()), 64'd1);
        if (pair_q.size() == 1) check("f_pair", 64'(pair_q[0]), 64'h6789_9876);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_i2s_rx_ctrl
`default_nettype wire

// File: doc/i2s_rx_ctrl.md
I2S_RX_CTRL -- requirements
Module: i2s_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits (legal 8..32).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i2s_sck  input  1  I2S bit clock, asynchronous to clk.
REQ-005 SHALL have port i2s_ws  input  1  I2S word select (0=left, 1=right), asynchronous.
REQ-006 SHALL have port i2s_sd  input  1  I2S serial data, asynchronous.
REQ-007 SHALL have port enable  input  1  receiver enable, synchronous to clk.
REQ-008 SHALL have port ovr_clr  input  1  one-cycle pulse clearing overrun.
REQ-009 SHALL have port sample_l  output  DATA_W  left sample, MSB-aligned.
REQ-010 SHALL have port sample_r  output  DATA_W  right sample, MSB-aligned.
REQ-011 SHALL have port sample_valid  output  1  stereo pair available.
REQ-012 SHALL have port sample_ready  input  1  consumer accepts pair when high with sample_valid.
REQ-013 SHALL have port overrun  output  1  sticky: a completed pair was dropped.

Function
REQ-014 SHALL pass i2s_sck, i2s_ws and i2s_sd each through a two-flop synchroniser, then register sck once more to form a one-clk sck_rise pulse (3 clk from pad edge to pulse).
REQ-015 SHALL require clk such that sck high and low phases each last at least 3 clk periods; no behaviour is defined below this.
REQ-016 SHALL sample synchronised ws and sd only on sck_rise; ws_d holds the ws value from the previous sck_rise.
REQ-017 SHALL implement states IDLE, SYNC, LEFT, RIGHT.
REQ-018 IDLE -> SYNC when enable=1; any state -> IDLE when enable=0, discarding partial words and clearing bit counter.
REQ-019 SYNC -> LEFT on the sck_rise where ws_d=1 and ws=0; the bit captured there is discarded (first partial frame dropped).
REQ-020 At each sck_rise in LEFT/RIGHT with ws==ws_d: write sd to bit DATA_W-1-cnt of the current shift register if cnt<DATA_W, else discard; cnt increments, saturating at DATA_W.
REQ-021 At a sck_rise with ws!=ws_d: that bit is the LSB of the current word (written per REQ-020), the word is committed, the next word's register is cleared, cnt reset to 0, state toggles LEFT<->RIGHT.
REQ-022 Words shorter than DATA_W SHALL be zero-padded in LSBs; longer words SHALL keep the first DATA_W bits received.
REQ-023 Commit of a right word SHALL form a pair with the last committed left word; sample_valid rises the clk after that commit.
REQ-024 sample_l/sample_r SHALL stay stable while sample_valid=1 and sample_ready=0.
REQ-025 Transfer occurs on a clk edge with sample_valid=1 and sample_ready=1; sample_valid drops next cycle unless a new pair loads that same cycle.
REQ-026 New pair completing with sample_valid=1 and sample_ready=1 same cycle: new pair loads, sample_valid stays 1, no overrun.
REQ-027 New pair completing with sample_valid=1 and sample_ready=0: new pair dropped, held pair kept, overrun set.
REQ-028 overrun SHALL clear on ovr_clr=1; if set and clear coincide, set wins.
REQ-029 enable=0 SHALL NOT clear a held pair, sample_valid or overrun.

Reset
REQ-030 On rst=1: state IDLE, cnt=0, sample_l=0, sample_r=0, sample_valid=0, overrun=0, all synchroniser and ws_d flops 0.
REQ-031 Reset assertion mid-word SHALL abort immediately; after release the block re-enters SYNC per REQ-018/019.

Structure
REQ-032 State encoding and MAX_DATA_W=32 SHALL reside in shared package i2s_pkg.
REQ-033 Input synchronisation plus edge detect SHALL be one sub-module i2s_edge_sync (ports clk, rst, sck, ws, sd in; sck_rise, ws_s, sd_s out), instantiated once.

Verification
REQ-034 DATA_W=16, 16-bit frames L=0xA5C3, R=0x1234, sample_ready=1 -> after first discarded frame, pair (0xA5C3,0x1234) with sample_valid high exactly one clk per frame.
REQ-035 DATA_W=16, 24-bit words L=0xABCDEF, R=0x123456 -> sample_l=0xABCD, sample_r=0x1234.
REQ-036 DATA_W=16, 8-bit words L=0x81, R=0x7F -> sample_l=0x8100, sample_r=0x7F00.
REQ-037 sample_ready=0 for three frames -> first pair held unchanged, overrun=1 after second pair completes; ovr_clr pulse -> overrun=0.
REQ-038 enable dropped mid-LEFT then raised -> no pair from aborted frame; next pair only after fresh ws 1->0 at sck_rise.
REQ-039 rst pulse mid-RIGHT with sample_valid=1 -> all outputs 0 next clk, sample_valid=0.
